// File: rtl/snake_body_ctrl_pkg.sv
// snake_body_ctrl_pkg: shared direction/state encodings and playfield defaults
package snake_body_ctrl_pkg;
    localparam int XSIZE_DEF    = 48;
    localparam int YSIZE_DEF    = 64;
    localparam int MAX_SIZE_DEF = 20;
    localparam int COORD_W      = 6;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RUN,
        ST_OVER
    } state_e;

    // Opposite directions differ only in the low bit.
    function automatic dir_e dir_opp(input dir_e d);
        return dir_e'({d[1], ~d[0]});
    endfunction
endpackage

// File: rtl/snake_collide.sv
// snake_collide: self-hit detect of a proposed head against the live body segments
module snake_collide
    import snake_body_ctrl_pkg::*;
#(
    parameter int MAX_SIZE = MAX_SIZE_DEF
) (
    input  logic [COORD_W-1:0]          head_x,
    input  logic [COORD_W-1:0]          head_y,
    input  logic [MAX_SIZE*COORD_W-1:0] body_x,
    input  logic [MAX_SIZE*COORD_W-1:0] body_y,
    input  logic [11:0]                 size,
    input  logic                        eat,
    output logic                        hit
);
    logic [11:0]         limit;
    logic [MAX_SIZE-1:0] hv;

    // The tail vacates this tick unless the snake grows.
    assign limit = eat ? size : size - 12'd1;

    for (genvar i = 0; i < MAX_SIZE; i++) begin : g_cmp
        assign hv[i] = (12'(i) < limit) &&
                       (body_x[i*COORD_W +: COORD_W] == head_x) &&
                       (body_y[i*COORD_W +: COORD_W] == head_y);
    end

    assign hit = |hv;
endmodule

// File: rtl/snake_body_ctrl.sv
// snake_body_ctrl: snake body/motion controller with item request handshake
module snake_body_ctrl
    import snake_body_ctrl_pkg::*;
#(
    parameter int XSIZE    = XSIZE_DEF,
    parameter int YSIZE    = YSIZE_DEF,
    parameter int MAX_SIZE = MAX_SIZE_DEF,
    parameter int INIT_X   = 24,
    parameter int INIT_Y   = 32
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    input  logic                          i_Tick,
    input  logic [1:0]                    i_Dir,
    input  logic                          i_Start,
    input  logic [COORD_W-1:0]            i_Item_x,
    input  logic [COORD_W-1:0]            i_Item_y,
    input  logic                          i_isMakeItem_Done,
    output logic [MAX_SIZE*COORD_W-1:0]   o_Body_x,
    output logic [MAX_SIZE*COORD_W-1:0]   o_Body_y,
    output logic [11:0]                   o_Body_size,
    output logic                          o_ItemNeed,
    output logic [COORD_W-1:0]            o_Item_x,
    output logic [COORD_W-1:0]            o_Item_y,
    output logic                          o_GameOver
);
    localparam int BW = MAX_SIZE * COORD_W;

    function automatic logic [BW-1:0] init_body(input int c0, input int c1, input int c2);
        logic [BW-1:0] b;
        b = '0;
        b[0*COORD_W +: COORD_W] = COORD_W'(c0);
        b[1*COORD_W +: COORD_W] = COORD_W'(c1);
        b[2*COORD_W +: COORD_W] = COORD_W'(c2);
        return b;
    endfunction

    localparam logic [BW-1:0] INIT_BX = init_body(INIT_X, INIT_X - 1, INIT_X - 2);
    localparam logic [BW-1:0] INIT_BY = init_body(INIT_Y, INIT_Y, INIT_Y);

    state_e               state_q, state_d;
    dir_e                 dir_q, dir_d, dir_nx;
    logic [BW-1:0]        body_x_q, body_x_d, body_y_q, body_y_d;
    logic [11:0]          size_q, size_d;
    logic [COORD_W-1:0]   item_x_q, item_x_d, item_y_q, item_y_d;
    logic [COORD_W-1:0]   hx, hy, nx, ny;
    logic                 wall, eat, self_hit;

    assign hx     = body_x_q[COORD_W-1:0];
    assign hy     = body_y_q[COORD_W-1:0];
    assign dir_nx = (dir_e'(i_Dir) == dir_opp(dir_q)) ? dir_q : dir_e'(i_Dir);
    assign nx     = (dir_nx == DIR_LEFT) ? hx - 6'd1 : (dir_nx == DIR_RIGHT) ? hx + 6'd1 : hx;
    assign ny     = (dir_nx == DIR_UP) ? hy - 6'd1 : (dir_nx == DIR_DOWN) ? hy + 6'd1 : hy;
    assign wall   = (nx == '0) || (nx == COORD_W'(XSIZE - 1)) ||
                    (ny == '0) || (ny == COORD_W'(YSIZE - 1));
    assign eat    = (nx == item_x_q) && (ny == item_y_q);

    snake_collide #(.MAX_SIZE(MAX_SIZE)) u_collide (
        .head_x (nx),
        .head_y (ny),
        .body_x (body_x_q),
        .body_y (body_y_q),
        .size   (size_q),
        .eat    (eat),
        .hit    (self_hit)
    );

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        body_x_d = body_x_q;
        body_y_d = body_y_q;
        size_d   = size_q;
        item_x_d = item_x_q;
        item_y_d = item_y_q;
        case (state_q)
            ST_IDLE: state_d = i_Start ? ST_REQ : ST_IDLE;
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: if (i_isMakeItem_Done) begin
                item_x_d = i_Item_x;
                item_y_d = i_Item_y;
                state_d  = ST_RUN;
            end
            ST_RUN: if (i_Tick) begin
                dir_d = dir_nx;
                if (wall || self_hit) begin
                    state_d = ST_OVER;
                end else begin
                    body_x_d = {body_x_q[BW-COORD_W-1:0], nx};
                    body_y_d = {body_y_q[BW-COORD_W-1:0], ny};
                    if (eat) begin
                        size_d  = (size_q == 12'(MAX_SIZE)) ? size_q : size_q + 12'd1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_OVER: if (i_Start) begin
                body_x_d = INIT_BX;
                body_y_d = INIT_BY;
                size_d   = 12'd3;
                dir_d    = DIR_RIGHT;
                state_d  = ST_REQ;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q  <= ST_IDLE;
            dir_q    <= DIR_RIGHT;
            body_x_q <= INIT_BX;
            body_y_q <= INIT_BY;
            size_q   <= 12'd3;
            item_x_q <= '0;
            item_y_q <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            body_x_q <= body_x_d;
            body_y_q <= body_y_d;
            size_q   <= size_d;
            item_x_q <= item_x_d;
            item_y_q <= item_y_d;
        end
    end

    assign o_Body_x    = body_x_q;
    assign o_Body_y    = body_y_q;
    assign o_Body_size = size_q;
    assign o_Item_x    = item_x_q;
    assign o_Item_y    = item_y_q;
    assign o_ItemNeed  = (state_q == ST_REQ);
    assign o_GameOver  = (state_q == ST_OVER);
endmodule

// File: tb/tb_snake_body_ctrl.sv
// tb_snake_body_ctrl: directed plus random stimulus against a cell-level game model
module tb_snake_body_ctrl;
    localparam int MAXS = 20;
    localparam int M_IDLE = 0, M_REQ = 1, M_WAIT = 2, M_RUN = 3, M_OVER = 4;

    logic                 i_Clk = 0, i_Rst = 1, i_Tick = 0, i_Start = 0, i_isMakeItem_Done = 0;
    logic [1:0]           i_Dir = 0;
    logic [5:0]           i_Item_x = 0, i_Item_y = 0;
    logic [MAXS*6-1:0]    o_Body_x, o_Body_y;
    logic [11:0]          o_Body_size;
    logic                 o_ItemNeed, o_GameOver;
    logic [5:0]           o_Item_x, o_Item_y;

    snake_body_ctrl dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Tick(i_Tick), .i_Dir(i_Dir), .i_Start(i_Start),
        .i_Item_x(i_Item_x), .i_Item_y(i_Item_y), .i_isMakeItem_Done(i_isMakeItem_Done),
        .o_Body_x(o_Body_x), .o_Body_y(o_Body_y), .o_Body_size(o_Body_size),
        .o_ItemNeed(o_ItemNeed), .o_Item_x(o_Item_x), .o_Item_y(o_Item_y), .o_GameOver(o_GameOver)
    );

    always #5 i_Clk = ~i_Clk;

    int n_vec = 0, n_bad = 0;
    int mx[MAXS], my[MAXS];
    int msz, mdir, mix, miy, mst;
    int dxt[4] = '{0, 0, -1, 1};
    int dyt[4] = '{-1, 1, 0, 0};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < MAXS; i++) begin
            mx[i] = 0;
            my[i] = 0;
        end
        mx[0] = 24; mx[1] = 23; mx[2] = 22;
        my[0] = 32; my[1] = 32; my[2] = 32;
        msz = 3; mdir = 3; mix = 0; miy = 0; mst = M_IDLE;
    endtask

    task automatic model_edge(input bit tk, input int d, input bit st, input bit dn, input int ix, input int iy);
        int nd, nx, ny, lim;
        bit hit, eat;
        case (mst)
            M_IDLE: if (st) mst = M_REQ;
            M_REQ:  mst = M_WAIT;
            M_WAIT: if (dn) begin mix = ix; miy = iy; mst = M_RUN; end
            M_RUN: if (tk) begin
                nd = (dxt[d] == -dxt[mdir] && dyt[d] == -dyt[mdir]) ? mdir : d;
                mdir = nd;
                nx = mx[0] + dxt[nd];
                ny = my[0] + dyt[nd];
                eat = (nx == mix && ny == miy);
                hit = (nx == 0 || nx == 47 || ny == 0 || ny == 63);
                lim = eat ? msz : msz - 1;
                for (int i = 0; i < lim; i++) if (mx[i] == nx && my[i] == ny) hit = 1;
                if (hit) mst = M_OVER;
                else begin
                    for (int i = MAXS - 1; i > 0; i--) begin
                        mx[i] = mx[i-1];
                        my[i] = my[i-1];
                    end
                    mx[0] = nx; my[0] = ny;
                    if (eat) begin
                        msz = (msz < MAXS) ? msz + 1 : MAXS;
                        mst = M_REQ;
                    end
                end
            end
            M_OVER: if (st) begin
                int keep_x = mix, keep_y = miy;
                model_reset();
                mix = keep_x; miy = keep_y; mst = M_REQ;
            end
            default: mst = M_IDLE;
        endcase
    endtask

    task automatic check_all();
        logic [MAXS*6-1:0] px, py;
        for (int i = 0; i < MAXS; i++) begin
            px[i*6 +: 6] = 6'(mx[i]);
            py[i*6 +: 6] = 6'(my[i]);
        end
        check("size", 128'(o_Body_size), 128'(msz));
        check("body_x", 128'(o_Body_x), 128'(px));
        check("body_y", 128'(o_Body_y), 128'(py));
        check("item_x", 128'(o_Item_x), 128'(mix));
        check("item_y", 128'(o_Item_y), 128'(miy));
        check("item_need", 128'(o_ItemNeed), 128'(mst == M_REQ));
        check("game_over", 128'(o_GameOver), 128'(mst == M_OVER));
    endtask

    task automatic step(input bit tk, input int d, input bit st, input bit dn, input int ix, input int iy);
        i_Tick = tk; i_Dir = 2'(d); i_Start = st; i_isMakeItem_Done = dn;
        i_Item_x = 6'(ix); i_Item_y = 6'(iy);
        @(posedge i_Clk);
        model_edge(tk, d, st, dn, ix, iy);
        #1 check_all();
    endtask

    initial begin
        int d, ix, iy, k;
        bit tk, st, dn;
        model_reset();
        #2 i_Rst = 0;
        #1 check_all();
        check("rst_head_x", 128'(o_Body_x[5:0]), 128'd24);
        check("rst_seg2_x", 128'(o_Body_x[17:12]), 128'd22);
        @(posedge i_Clk);
        #3 i_Rst = 1;
        // start, item handshake, two right ticks ending in an eat
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 26, 32);
        step(1, 3, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0);
        check("eat_head_x", 128'(o_Body_x[5:0]), 128'd26);
        check("eat_seg3_x", 128'(o_Body_x[23:18]), 128'd23);
        check("eat_size", 128'(o_Body_size), 128'd4);
        // ticks during REQ/WAIT dropped, tick with done dropped, reverse ignored
        for (int i = 0; i < 4; i++) step(1, 2, 0, 0, 0, 0);
        step(1, 2, 0, 1, 27, 32);
        step(1, 2, 0, 0, 0, 0);
        check("rev_head_x", 128'(o_Body_x[5:0]), 128'd27);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 5, 5);
        step(1, 1, 0, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("self_over", 128'(o_GameOver), 128'd1);
        step(1, 3, 0, 0, 0, 0);
        // restart, grow to 4, then chase the tail
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 25, 32);
        step(1, 3, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 5, 5);
        step(1, 1, 0, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("tail_ok", 128'({o_GameOver, o_Body_x[5:0], o_Body_y[5:0]}), 128'({1'b0, 6'd24, 6'd32}));
        // run into the right wall
        for (int i = 0; i < 23; i++) step(1, 3, 0, 0, 0, 0);
        check("wall_head_x", 128'(o_Body_x[5:0]), 128'd46);
        check("wall_over", 128'(o_GameOver), 128'd1);
        step(0, 0, 1, 0, 0, 0);
        // asynchronous reset while a request is pending
        #2 i_Rst = 0;
        model_reset();
        #1 check_all();
        #2 i_Rst = 1;
        // random play
        for (int n = 0; n < 4000; n++) begin
            tk = ($urandom_range(0, 2) == 0);
            d  = ($urandom_range(0, 4) < 3) ? mdir : int'($urandom_range(0, 3));
            st = (mst == M_OVER || mst == M_IDLE) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 49) == 0);
            dn = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 0) begin
                k  = int'($urandom_range(1, 4));
                ix = mx[0] + dxt[mdir] * k;
                iy = my[0] + dyt[mdir] * k;
                ix = (ix < 1) ? 1 : (ix > 46) ? 46 : ix;
                iy = (iy < 1) ? 1 : (iy > 62) ? 62 : iy;
            end else begin
                ix = int'($urandom_range(1, 46));
                iy = int'($urandom_range(1, 62));
            end
            step(tk, d, st, dn, ix, iy);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
